addsub_nibble_serial: RTL
=========================

Name: addsub_nibble_serial

Overview:
- Multi-cycle 16-bit signed saturating adder/subtractor built around one instance of the team's 4-bit carry-lookahead slice (CLA_4bit, ports A, B, Cin, Sum, Cout).
- The block sequences the operands into that slice one nibble per cycle, holding the inter-nibble carry in a flop, then saturates the result and produces flags.
- It feeds the slice and consumes its outputs, replacing four cascaded slices on area-critical paths.

Parameters:
- NIB_CNT, 4, number of nibbles processed; fixed at 4 (16-bit datapath), not for override.

Ports:
- clk    input   1   system clock, rising edge
- rst    input   1   reset, asynchronous, active-high
- start  input   1   request; sampled only when busy=0
- sub    input   1   1 = a - b, 0 = a + b; sampled with start
- a      input   16  signed operand A; sampled with start
- b      input   16  signed operand B; sampled with start
- busy   output  1   high from the edge after start acceptance through the FIN cycle
- done   output  1   one-cycle pulse; sum and flags valid from this cycle onward
- sum    output  16  saturated signed result, registered; held until next completion
- ovfl   output  1   signed overflow occurred, result saturated; registered
- zero   output  1   sum == 0; registered
- neg    output  1   sum[15]; registered

Behaviour:
- Clock and reset: single clock domain; one clock (clk); reset is asynchronous and active-high (rst).
- Reset values: state=IDLE, busy=0, done=0, sum=0, ovfl=0, zero=0, neg=0, internal operand/raw/carry/index registers all 0.
- States: IDLE, RUN, FIN.
- IDLE:
  - start=1 at edge E0: latch opA=a, opB = sub ? ~b : b, carry=sub, idx=0; go to RUN; busy=1 after E0.
  - start=0: stay in IDLE.
- RUN:
  - Slice inputs are opA[4*idx+3:4*idx], opB[4*idx+3:4*idx], Cin=carry.
  - Each edge: raw[4*idx+3:4*idx] <= Sum; carry <= Cout; idx <= idx+1.
  - On the edge with idx==3 (E4): go to FIN.
- FIN: combinational saturation from raw, opA[15], opB[15].
  - Overflow condition: opA[15]==opB[15] and raw[15]!=opA[15].
  - On overflow: result = opA[15] ? 16'h8000 : 16'h7FFF; otherwise result = raw.
  - Final carry is discarded.
  - At edge E5: sum<=result, ovfl<=overflow, zero<=(result==0), neg<=result[15], done<=1; go to IDLE.
- After E5: busy=0, done=1 for exactly one cycle; done<=0 at E6 unless another completion occurs.
- Latency: start accepted at E0, result visible after E5 (5 cycles). Back-to-back throughput: one op per 6 cycles, since start is accepted at E5 in IDLE only on the next edge.
- start, sub, a, b are ignored while busy=1 (RUN or FIN); latched operands are unaffected by input changes.
- sum and flags change only at FIN completion or reset; they hold across new operations until those complete.
- Reset mid-operation (any state): immediate return to IDLE with all reset values; the partial result is discarded; no done pulse.
- Arithmetic is two's complement, 16-bit; subtraction uses ~b plus carry-in 1. 16'h8000 - 16'h8000 = 0 with no overflow.
- Exactly one CLA_4bit instance. Its Prop_Val and Gen_Val outputs are left unconnected.

Test Plan:
- a=16'h0FFF, b=16'h0001, sub=0 -> after 5 cycles done=1, sum=16'h1000, ovfl=0, zero=0, neg=0 (carry ripples across nibbles 0-2).
- a=16'h7FFF, b=16'h0001, sub=0 -> sum=16'h7FFF, ovfl=1, neg=0; a=16'h8000, b=16'h8000, sub=0 -> sum=16'h8000, ovfl=1, neg=1.
- a=16'h8000, b=16'h0001, sub=1 -> sum=16'h8000, ovfl=1, neg=1; a=16'h0005, b=16'h0005, sub=1 -> sum=0, zero=1, ovfl=0.
- Start a=16'h1234, b=16'h0FED, sub=0; re-pulse start with a=16'hFFFF, b=16'hFFFF during RUN -> single done, sum=16'h2221, no second done.
- Start an op, assert rst for 1 cycle during RUN (idx=2) -> busy=0, sum=0, flags 0, no done. A subsequent op a=16'hFFFE, b=16'h0003, sub=1 yields sum=16'hFFFB, neg=1.
- Back-to-back: start held high continuously -> done pulses every 6 cycles, busy low exactly one cycle between ops.

Source files
------------

// File: rtl/addsub_nibble_serial.sv
// 16-bit signed saturating add/subtract that time-shares a single 4-bit
// carry-lookahead slice, processing one nibble per cycle, with zero/neg/ovfl flags.
module addsub_nibble_serial (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sub,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] sum,
  output logic        ovfl,
  output logic        zero,
  output logic        neg
);

  localparam int NIB_CNT = 4;
  localparam logic [1:0] LAST_IDX = 2'(NIB_CNT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] op_a_q, op_a_d;
  logic [15:0] op_b_q, op_b_d;
  logic [15:0] raw_q, raw_d;
  logic        carry_q, carry_d;
  logic [1:0]  idx_q, idx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] sum_q, sum_d;
  logic        ovfl_q, ovfl_d;
  logic        zero_q, zero_d;
  logic        neg_q, neg_d;

  logic [3:0]  slice_a, slice_b, slice_sum;
  logic        slice_cout;
  logic        slice_p_unused, slice_g_unused;
  logic        sat_ovf;
  logic [15:0] sat_result;

  assign slice_a = op_a_q[{idx_q, 2'b00} +: 4];
  assign slice_b = op_b_q[{idx_q, 2'b00} +: 4];

  CLA_4bit u_cla (
    .A        (slice_a),
    .B        (slice_b),
    .Cin      (carry_q),
    .Sum      (slice_sum),
    .Cout     (slice_cout),
    .Prop_Val (slice_p_unused),
    .Gen_Val  (slice_g_unused)
  );

  // The carry out of the top nibble is discarded; overflow comes from the sign bits.
  assign sat_ovf    = (op_a_q[15] == op_b_q[15]) && (raw_q[15] != op_a_q[15]);
  assign sat_result = sat_ovf ? (op_a_q[15] ? 16'h8000 : 16'h7FFF) : raw_q;

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    raw_d   = raw_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    ovfl_d  = ovfl_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_a_d  = a;
          op_b_d  = sub ? ~b : b;
          carry_d = sub;
          idx_d   = 2'd0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        raw_d[{idx_q, 2'b00} +: 4] = slice_sum;
        carry_d = slice_cout;
        idx_d   = idx_q + 2'd1;
        if (idx_q == LAST_IDX) state_d = FIN;
      end
      FIN: begin
        sum_d   = sat_result;
        ovfl_d  = sat_ovf;
        zero_d  = (sat_result == 16'h0000);
        neg_d   = sat_result[15];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_a_q  <= 16'h0000;
      op_b_q  <= 16'h0000;
      raw_q   <= 16'h0000;
      carry_q <= 1'b0;
      idx_q   <= 2'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= 16'h0000;
      ovfl_q  <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      raw_q   <= raw_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      ovfl_q  <= ovfl_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign ovfl = ovfl_q;
  assign zero = zero_q;
  assign neg  = neg_q;

endmodule

module CLA_4bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout,
  output logic       Prop_Val,
  output logic       Gen_Val
);

  logic [3:0] p, g;
  logic [3:0] c;

  assign p = A ^ B;
  assign g = A & B;

  assign c[0] = Cin;
  assign c[1] = g[0] | (p[0] & Cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & Cin);

  assign Prop_Val = &p;
  assign Gen_Val  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign Cout     = Gen_Val | (Prop_Val & Cin);
  assign Sum      = p ^ c;

endmodule
